// File: rtl/control_pkg.sv
// Shared CPU constants for the main control unit: ALU op classes, opcode values and match masks,
// and the packed control-word type.
package control_pkg;

  localparam logic [1:0] ALUOp_DTYPE = 2'b00;
  localparam logic [1:0] ALUOp_CBZ   = 2'b01;
  localparam logic [1:0] ALUOp_RTYPE = 2'b10;

  localparam logic [10:0] OpAdd  = 11'h458;
  localparam logic [10:0] OpSub  = 11'h658;
  localparam logic [10:0] OpAnd  = 11'h450;
  localparam logic [10:0] OpOrr  = 11'h550;
  localparam logic [10:0] OpLdur = 11'h7C2;
  localparam logic [10:0] OpStur = 11'h7C0;
  localparam logic [10:0] OpCbz  = 11'h5A0;
  localparam logic [10:0] OpB    = 11'h0A0;

  localparam logic [10:0] OpMaskFull = 11'h7FF;
  localparam logic [10:0] OpMaskCbz  = 11'h7F8;
  localparam logic [10:0] OpMaskB    = 11'h7E0;

  typedef struct packed {
    logic       reg2_loc;
    logic       uncondbranch;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
  } ctrl_t;

  function automatic logic op_match(input logic [10:0] op, input logic [10:0] val,
                                    input logic [10:0] mask);
    return (op & mask) == (val & mask);
  endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational opcode decode into the control word.
// CONTROL_INVALID_OP_EN adds the invalid_op flag for opcodes that match no rule.
module control_decode
  import control_pkg::*;
(
  input  logic [10:0] opcode,
`ifdef CONTROL_INVALID_OP_EN
  output logic        invalid_op,
`endif
  output ctrl_t       ctrl
);

  logic is_rtype, is_ldur, is_stur, is_cbz, is_b;

  assign is_rtype = op_match(opcode, OpAdd, OpMaskFull) | op_match(opcode, OpSub, OpMaskFull) |
                    op_match(opcode, OpAnd, OpMaskFull) | op_match(opcode, OpOrr, OpMaskFull);
  assign is_ldur  = op_match(opcode, OpLdur, OpMaskFull);
  assign is_stur  = op_match(opcode, OpStur, OpMaskFull);
  assign is_cbz   = op_match(opcode, OpCbz, OpMaskCbz);
  assign is_b     = op_match(opcode, OpB, OpMaskB);

`ifdef CONTROL_INVALID_OP_EN
  assign invalid_op = ~(is_rtype | is_ldur | is_stur | is_cbz | is_b);
`endif

  // Unmatched opcodes fall through to the all-zero word: no memory or register side effects.
  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = ALUOp_DTYPE;
    if (is_rtype) begin
      ctrl.alu_op    = ALUOp_RTYPE;
      ctrl.reg_write = 1'b1;
    end else if (is_ldur) begin
      ctrl.mem_read   = 1'b1;
      ctrl.mem_to_reg = 1'b1;
      ctrl.alu_src    = 1'b1;
      ctrl.reg_write  = 1'b1;
    end else if (is_stur) begin
      ctrl.reg2_loc  = 1'b1;
      ctrl.mem_write = 1'b1;
      ctrl.alu_src   = 1'b1;
    end else if (is_cbz) begin
      ctrl.reg2_loc = 1'b1;
      ctrl.branch   = 1'b1;
      ctrl.alu_op   = ALUOp_CBZ;
    end else if (is_b) begin
      ctrl.uncondbranch = 1'b1;
    end
  end

endmodule

// File: rtl/control.sv
// Main control unit: registers the decoded control word once per clock.
// CONTROL_INVALID_OP_EN adds a registered invalid_op output.
module control
  import control_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] opcode,
  output logic        reg2_loc,
  output logic        uncondbranch,
  output logic        branch,
  output logic        mem_read,
  output logic        mem_to_reg,
  output logic [1:0]  alu_op,
  output logic        mem_write,
  output logic        alu_src,
`ifdef CONTROL_INVALID_OP_EN
  output logic        invalid_op,
`endif
  output logic        reg_write
);

  ctrl_t ctrl_d, ctrl_q;

`ifdef CONTROL_INVALID_OP_EN
  logic invalid_d, invalid_q;

  control_decode u_decode (
    .opcode     (opcode),
    .invalid_op (invalid_d),
    .ctrl       (ctrl_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) invalid_q <= 1'b0;
    else        invalid_q <= invalid_d;
  end

  assign invalid_op = invalid_q;
`else
  control_decode u_decode (
    .opcode (opcode),
    .ctrl   (ctrl_d)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ctrl_q <= '0;
    else        ctrl_q <= ctrl_d;
  end

  assign reg2_loc     = ctrl_q.reg2_loc;
  assign uncondbranch = ctrl_q.uncondbranch;
  assign branch       = ctrl_q.branch;
  assign mem_read     = ctrl_q.mem_read;
  assign mem_to_reg   = ctrl_q.mem_to_reg;
  assign alu_op       = ctrl_q.alu_op;
  assign mem_write    = ctrl_q.mem_write;
  assign alu_src      = ctrl_q.alu_src;
  assign reg_write    = ctrl_q.reg_write;

endmodule

// File: tb/tb_control.sv
// Self-checking bench for control: vector table, reset sequences and random opcodes
// against a range-based reference model.
module tb_control;

  logic        clk;
  logic        rst_n;
  logic [10:0] opcode;
  logic        reg2_loc, uncondbranch, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
  logic [1:0]  alu_op;
  logic        invalid_op;
  logic [9:0]  act;

  int n_checks = 0;
  int n_fail   = 0;

  // {reg2_loc, uncondbranch, branch, mem_read, mem_to_reg, alu_op[1:0], mem_write, alu_src, reg_write}
  localparam logic [9:0] VecR    = 10'b0000010001;
  localparam logic [9:0] VecLdur = 10'b0001100011;
  localparam logic [9:0] VecStur = 10'b1000000110;
  localparam logic [9:0] VecCbz  = 10'b1010001000;
  localparam logic [9:0] VecB    = 10'b0100000000;
  localparam logic [9:0] VecNone = 10'b0000000000;

  typedef struct {
    logic [10:0] op;
    logic [9:0]  vec;
    logic        inv;
  } vec_t;

  vec_t tbl[16];

`ifdef CONTROL_INVALID_OP_EN
  control dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .reg2_loc     (reg2_loc),
    .uncondbranch (uncondbranch),
    .branch       (branch),
    .mem_read     (mem_read),
    .mem_to_reg   (mem_to_reg),
    .alu_op       (alu_op),
    .mem_write    (mem_write),
    .alu_src      (alu_src),
    .invalid_op   (invalid_op),
    .reg_write    (reg_write)
  );
`else
  control dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .reg2_loc     (reg2_loc),
    .uncondbranch (uncondbranch),
    .branch       (branch),
    .mem_read     (mem_read),
    .mem_to_reg   (mem_to_reg),
    .alu_op       (alu_op),
    .mem_write    (mem_write),
    .alu_src      (alu_src),
    .reg_write    (reg_write)
  );
  assign invalid_op = 1'b0;
`endif

  assign act = {reg2_loc, uncondbranch, branch, mem_read, mem_to_reg, alu_op, mem_write, alu_src,
                reg_write};

  always #5 clk = ~clk;

  // Reference model: {invalid, vector} from opcode ranges.
  function automatic logic [10:0] ref_model(input int op);
    if (op == 'h458 || op == 'h658 || op == 'h450 || op == 'h550) return {1'b0, VecR};
    if (op == 'h7C2) return {1'b0, VecLdur};
    if (op == 'h7C0) return {1'b0, VecStur};
    if (op >= 'h5A0 && op <= 'h5A7) return {1'b0, VecCbz};
    if (op >= 'h0A0 && op <= 'h0BF) return {1'b0, VecB};
    return {1'b1, VecNone};
  endfunction

  task automatic check(input string name, input logic [9:0] actual, input logic [9:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, actual, expected);
    end
  endtask

  task automatic check_inv(input string name, input logic expected);
`ifdef CONTROL_INVALID_OP_EN
    check({name, " invalid_op"}, {9'b0, invalid_op}, {9'b0, expected});
`else
    if (expected === 1'bx) $display("note: %s", name);
`endif
  endtask

  // Drive opcode away from the edge, confirm outputs hold, then confirm the new decode.
  task automatic apply(input logic [10:0] op, input logic [9:0] prev, input logic [9:0] exp,
                       input logic inv);
    string name;
    name = $sformatf("op_%03h", op);
    @(negedge clk);
    opcode = op;
    #1 check({name, " hold"}, act, prev);
    @(posedge clk);
    #1 check(name, act, exp);
    check_inv(name, inv);
  endtask

  initial begin
    logic [9:0]  prev;
    logic [10:0] m;
    logic [10:0] op;

    tbl[0]  = '{11'h458, VecR,    1'b0};
    tbl[1]  = '{11'h658, VecR,    1'b0};
    tbl[2]  = '{11'h450, VecR,    1'b0};
    tbl[3]  = '{11'h550, VecR,    1'b0};
    tbl[4]  = '{11'h7C2, VecLdur, 1'b0};
    tbl[5]  = '{11'h7C0, VecStur, 1'b0};
    tbl[6]  = '{11'h5A0, VecCbz,  1'b0};
    tbl[7]  = '{11'h5A7, VecCbz,  1'b0};
    tbl[8]  = '{11'h0A0, VecB,    1'b0};
    tbl[9]  = '{11'h0AF, VecB,    1'b0};
    tbl[10] = '{11'h0BF, VecB,    1'b0};
    tbl[11] = '{11'h5A8, VecNone, 1'b1};
    tbl[12] = '{11'h09F, VecNone, 1'b1};
    tbl[13] = '{11'h7C3, VecNone, 1'b1};
    tbl[14] = '{11'h765, VecNone, 1'b1};
    tbl[15] = '{11'h458, VecR,    1'b0};

    clk    = 1'b0;
    rst_n  = 1'b1;
    opcode = 11'h458;

    // Reset clears outputs before any clock edge.
    #1 rst_n = 1'b0;
    #1 check("reset_async", act, VecNone);
    check_inv("reset_async", 1'b0);
    repeat (2) @(posedge clk);
    #1 check("reset_held", act, VecNone);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("release_no_edge", act, VecNone);
    @(posedge clk);
    #1 check("first_edge_add", act, VecR);
    check_inv("first_edge_add", 1'b0);

    prev = VecR;
    for (int i = 0; i < 16; i++) begin
      apply(tbl[i].op, prev, tbl[i].vec, tbl[i].inv);
      prev = tbl[i].vec;
    end

    // Half-period reset pulse while decoding LDUR.
    apply(11'h7C2, prev, VecLdur, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("midreset_clear", act, VecNone);
    #2 rst_n = 1'b1;
    #1 check("midreset_release", act, VecNone);
    @(posedge clk);
    #1 check("midreset_ldur", act, VecLdur);
    prev = VecLdur;

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 5))
        0: begin
          case ($urandom_range(0, 3))
            0:       op = 11'h458;
            1:       op = 11'h658;
            2:       op = 11'h450;
            default: op = 11'h550;
          endcase
        end
        1:       op = ($urandom_range(0, 1) != 0) ? 11'h7C2 : 11'h7C0;
        2:       op = 11'h5A0 + 11'($urandom_range(0, 7));
        3:       op = 11'h0A0 + 11'($urandom_range(0, 31));
        default: op = 11'($urandom);
      endcase
      m = ref_model(int'(op));
      apply(op, prev, m[9:0], m[10]);
      prev = m[9:0];
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
